// File: rtl/intdiv_sd2_divider.sv
// Registered signed integer divider: truncating quotient z and remainder r of x / y,
// built as an N-row combinational non-restoring array with one cycle of latency.
module intdiv_sd2_divider #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  output logic [N-1:0] z,
  output logic [N-1:0] r
);

  // Partial remainders need two guard bits: they swing over [-2|y|, 2|y|+1].
  localparam int W = N + 2;

  logic [N-1:0]        w_a;
  logic [N-1:0]        w_d;
  logic signed [W-1:0] w_dext;
  logic signed [W-1:0] w_rem [0:N];
  logic [N-1:0]        w_q;
  logic [N-1:0]        w_rmag;
  logic                w_neg_q;
  logic                w_div0;
  logic [N-1:0]        w_z;
  logic [N-1:0]        w_r;

  logic         r_valid;
  logic [N-1:0] r_z;
  logic [N-1:0] r_r;

  // Magnitudes; -2^(N-1) maps to the unsigned pattern 2^(N-1), which still fits in N bits.
  assign w_a    = x[N-1] ? -x : x;
  assign w_d    = y[N-1] ? -y : y;
  assign w_dext = {2'b00, w_d};

  assign w_rem[0] = '0;

  // Each row shifts in one dividend bit, then adds or subtracts |y| depending on the
  // sign of the running remainder. The quotient bit is the complement of the new sign.
  for (genvar k = 0; k < N; k++) begin : g_row
    logic signed [W-1:0] w_shift;
    assign w_shift      = {w_rem[k][W-2:0], w_a[N-1-k]};
    assign w_rem[k+1]   = w_rem[k][W-1] ? (w_shift + w_dext) : (w_shift - w_dext);
    assign w_q[N-1-k]   = ~w_rem[k+1][W-1];
  end

  // A negative final remainder is restored by one add of |y|; the quotient bits already
  // account for it, so no separate quotient correction is needed.
  assign w_rmag  = w_rem[N][N-1:0] + (w_rem[N][W-1] ? w_d : '0);

  assign w_neg_q = x[N-1] ^ y[N-1];
  assign w_div0  = (y == '0);

  assign w_z = w_div0 ? '1 : (w_neg_q ? -w_q : w_q);
  assign w_r = w_div0 ? x  : (x[N-1] ? -w_rmag : w_rmag);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_z     <= '0;
      r_r     <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_z <= w_z;
        r_r <= w_r;
      end
    end
  end

  assign out_valid = r_valid;
  assign z         = r_z;
  assign r         = r_r;

endmodule

// File: tb/tb_intdiv_sd2_divider.sv
// Self-checking bench for intdiv_sd2_divider: directed table, timing/reset checks,
// random and exhaustive N=5 streams compared against a truncating-division model.
module tb_intdiv_sd2_divider;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic [N-1:0] z;
  logic [N-1:0] r;

  int checks = 0;
  int errors = 0;

  logic         pend_v = 1'b0;
  logic [N-1:0] pend_z;
  logic [N-1:0] pend_r;
  string        pend_tag;

  always #5 clk = ~clk;

  intdiv_sd2_divider #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .z        (z),
    .r        (r)
  );

  // Reference: C-style truncating division on plain integers, wrapped to N bits.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
    int xi, yi, q, m;
    logic [N-1:0] mz, mr;
    xi = int'($signed(a));
    yi = int'($signed(b));
    if (yi == 0) begin
      mz = '1;
      mr = a;
    end else begin
      q  = xi / yi;
      m  = xi - q * yi;
      mz = q[N-1:0];
      mr = m[N-1:0];
    end
    return {mz, mr};
  endfunction

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    in_valid = v;
    x        = a;
    y        = b;
  endtask

  // One streaming step: at the negedge, check the result of the previous step, then drive.
  task automatic stream_step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                             input string tag);
    logic [2*N-1:0] e;
    @(negedge clk);
    if (pend_v) begin
      check({pend_tag, ".valid"}, {{(N-1){1'b0}}, out_valid}, N'(1));
      check({pend_tag, ".z"}, z, pend_z);
      check({pend_tag, ".r"}, r, pend_r);
    end
    in_valid = v;
    x        = a;
    y        = b;
    e        = model(a, b);
    pend_v   = v;
    pend_z   = e[2*N-1:N];
    pend_r   = e[N-1:0];
    pend_tag = tag;
  endtask

  int tx[19] = '{7, 7, 8, 14, 14, 3, 15, 0, -5, -7, -15, -1, 1, 1, 5, -7, -11, 15, -16};
  int ty[19] = '{3, 2, 2, 5, 9, 14, 15, 15, 3, 3, 15, 1, -1, -15, -15, -4, -15, 0, -1};
  int tz[19] = '{2, 3, 4, 2, 1, 0, 1, 0, -1, -2, -1, -1, -1, 0, 0, 1, 0, -1, -16};
  int tr[19] = '{1, 1, 0, 4, 5, 3, 0, 0, -2, -1, 0, 0, 0, 1, 5, -3, -11, 15, 0};

  initial begin
    logic [N-1:0] last_z, last_r;
    rst      = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;

    // Reset state
    #12;
    check("reset.valid", {{(N-1){1'b0}}, out_valid}, '0);
    check("reset.z", z, '0);
    check("reset.r", r, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle.valid", {{(N-1){1'b0}}, out_valid}, '0);

    // Directed table from the operation rules
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, tx[i][N-1:0], ty[i][N-1:0]);
      @(posedge clk); #1;
      check($sformatf("dir%0d.valid", i), {{(N-1){1'b0}}, out_valid}, N'(1));
      check($sformatf("dir%0d.z(%0d/%0d)", i, tx[i], ty[i]), z, tz[i][N-1:0]);
      check($sformatf("dir%0d.r(%0d/%0d)", i, tx[i], ty[i]), r, tr[i][N-1:0]);
    end
    last_z = tz[18][N-1:0];
    last_r = tr[18][N-1:0];

    // in_valid low: out_valid drops, results hold
    drive(1'b0, 5'($urandom), 5'($urandom_range(1, 31)));
    @(posedge clk); #1;
    check("hold.valid", {{(N-1){1'b0}}, out_valid}, '0);
    check("hold.z", z, last_z);
    check("hold.r", r, last_r);

    // Back-to-back: four consecutive accepted inputs
    for (int i = 0; i < 4; i++)
      stream_step(1'b1, 5'($urandom), 5'($urandom), $sformatf("b2b%0d", i));
    stream_step(1'b0, '0, '0, "b2b_end");
    @(negedge clk);
    check("b2b_end.valid", {{(N-1){1'b0}}, out_valid}, '0);
    pend_v = 1'b0;

    // Reset mid-stream clears outputs at once and drops the pending result
    drive(1'b1, 5'd7, 5'd3);
    @(posedge clk); #1;
    check("pre_rst.z", z, 5'd2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst.valid", {{(N-1){1'b0}}, out_valid}, '0);
    check("mid_rst.z", z, '0);
    check("mid_rst.r", r, '0);
    @(posedge clk); #1;
    check("rst_held.valid", {{(N-1){1'b0}}, out_valid}, '0);
    check("rst_held.z", z, '0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst.valid", {{(N-1){1'b0}}, out_valid}, '0);
    drive(1'b1, 5'd14, 5'd5);
    @(posedge clk); #1;
    check("first_after_rst.valid", {{(N-1){1'b0}}, out_valid}, N'(1));
    check("first_after_rst.z", z, 5'd2);
    check("first_after_rst.r", r, 5'd4);

    // Random stream with occasional idle cycles
    for (int i = 0; i < 200; i++)
      stream_step(($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
                  $sformatf("rnd%0d", i));

    // Exhaustive sweep of all nonzero-divisor pairs, back to back
    for (int a = 0; a < 32; a++)
      for (int b = 1; b < 32; b++)
        stream_step(1'b1, a[N-1:0], b[N-1:0], $sformatf("sweep_%0d_%0d", a, b));
    stream_step(1'b0, '0, '0, "flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
